// File: rtl/fetch_pkg.sv
// Shared fetch definitions: the NOP encoding and the instruction queue entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        misaligned;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions; flush empties it and may load one entry at once.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] wr_idx;
  logic             do_push;
  logic             do_pop;
  fetch_entry_t     entries [DEPTH];

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A flush restarts both pointers, so a push in the same cycle lands in slot 0.
  assign wr_idx  = flush ? '0 : wr_ptr_reg;
  assign do_push = push && (flush || (count_reg != FULL_CNT));
  assign do_pop  = pop && !flush && (count_reg != '0);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    fetch_entry_t entry_reg;
    always_ff @(posedge clk) begin
      if (do_push && (wr_idx == PTR_W'(gi))) begin
        entry_reg <= push_data;
      end
    end
    assign entries[gi] = entry_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= do_push ? bump('0) : '0;
      count_reg  <= do_push ? CNT_W'(1) : '0;
    end else begin
      if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = entries[rd_ptr_reg];
  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC generation, queue credit accounting and redirect handling.
// Define FETCH_MISALIGN_CHECK_EN to add insn_misaligned and trap misaligned redirect targets.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        insn_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        insn_misaligned
`endif
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [31:0]      pc_reg;
  logic             inflight_reg;
  logic [31:0]      inflight_pc_reg;
  logic             halt_reg;

  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  fetch_entry_t     q_head;
  fetch_entry_t     push_data;
  logic             push;
  logic             pop;
  logic             issue;
  logic             redirect_bad;
  logic             credit_ok;
  logic [OCC_W-1:0] occupancy;
  logic [31:0]      target;

  assign target = word_align(redirect_pc);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_bad = redirect_en && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
`endif

  // A redirect flushes the queue, so a pop in that cycle is meaningless.
  assign pop = insn_valid && insn_ready && !redirect_en;

  // Entries held plus the one word on its way back must fit once this cycle's pop leaves.
  assign occupancy = OCC_W'(q_count) + OCC_W'(inflight_reg) - OCC_W'(pop);
  assign credit_ok = occupancy < OCC_W'(QDEPTH);

  always_comb begin
    issue = 1'b0;
    if (reset) begin
      issue = 1'b0;
    end else if (redirect_en) begin
      issue = !redirect_bad;
    end else begin
      issue = !halt_reg && credit_ok;
    end
  end

  assign imem_re   = issue;
  assign imem_addr = redirect_en ? target : pc_reg;

  always_comb begin
    push      = inflight_reg && !redirect_en;
    push_data = '{pc: inflight_pc_reg, insn: imem_rdata, misaligned: 1'b0};
    if (redirect_bad) begin
      push      = 1'b1;
      push_data = '{pc: redirect_pc, insn: NOP, misaligned: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= RESET_PC;
      halt_reg        <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= imem_addr;
      if (redirect_en) begin
        pc_reg   <= issue ? target + 32'd4 : target;
        halt_reg <= redirect_bad;
      end else if (issue) begin
        pc_reg <= pc_reg + 32'd4;
      end
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_en),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign insn_valid = !q_empty;
  assign insn       = q_empty ? NOP : q_head.insn;
  assign insn_pc    = q_empty ? RESET_PC : q_head.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign insn_misaligned = !q_empty && q_head.misaligned;
`endif

  // Full is implied by the credit check; low target bits only matter with the misalign trap.
  logic unused_bits;
  assign unused_bits = q_full ^ q_head.misaligned ^ redirect_pc[1] ^ redirect_pc[0];

endmodule

// File: tb/tb_fetch.sv
// Randomised and directed bench for fetch against an in-order stream model of expected PCs.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        insn_valid;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        insn_misaligned;
`endif

  fetch #(
    .RESET_PC(RESET_PC),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_re    (imem_re),
    .imem_rdata (imem_rdata),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .insn_valid (insn_valid),
    .insn       (insn),
    .insn_pc    (insn_pc),
    .insn_ready (insn_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .insn_misaligned(insn_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] scramble = 32'h0;

  // Stream model: the next PC the decoder must see, and the next PC memory must be asked for.
  logic [31:0] exp_pc;
  logic [31:0] req_pc;
  int          issued;
  int          consumed;
  logic        stall_prev;
  logic        redir_prev;
  logic [31:0] prev_pc;
  logic [31:0] prev_insn;
  logic        last_re;
  logic [31:0] last_addr;
  logic        last_valid;
  logic [31:0] last_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ scramble;
  endfunction

  // One-cycle-latency instruction memory; unrequested cycles return junk.
  always @(posedge clk) imem_rdata <= imem_re ? word_of(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input logic [31:0] start);
    exp_pc = start; req_pc = start; issued = 0; consumed = 0;
    stall_prev = 1'b0; redir_prev = 1'b0;
  endtask

  // Entered and left at posedge+1; outputs sampled mid-cycle.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    insn_ready = rdy; redirect_en = redir; redirect_pc = rpc;
    #2;
    if (redir_prev) chkb("valid_after_redirect", insn_valid, 1'b0);
    if (stall_prev && insn_valid) begin
      chk("stall_pc", insn_pc, prev_pc);
      chk("stall_insn", insn, prev_insn);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    if (insn_valid) chkb("not_misaligned", insn_misaligned, 1'b0);
`endif
    if (redir) begin
      exp_pc = {rpc[31:2], 2'b00}; req_pc = exp_pc; issued = 0; consumed = 0;
      chkb("redirect_issue", imem_re, 1'b1);
    end else if (insn_valid && rdy) begin
      chk("stream_pc", insn_pc, exp_pc);
      chk("stream_insn", insn, word_of(exp_pc));
      exp_pc += 32'd4; consumed++;
    end
    if (imem_re) begin
      chk("fetch_addr", imem_addr, req_pc);
      req_pc += 32'd4; issued++;
      chkb("credit", (issued - consumed) <= QDEPTH, 1'b1);
    end
    stall_prev = insn_valid && !rdy && !redir;
    redir_prev = redir;
    prev_pc = insn_pc; prev_insn = insn;
    last_re = imem_re; last_addr = imem_addr; last_valid = insn_valid; last_pc = insn_pc;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; insn_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0;
    repeat (n) begin
      @(posedge clk); #1;
      chkb("rst_re", imem_re, 1'b0);
      chkb("rst_valid", insn_valid, 1'b0);
      chk("rst_insn", insn, NOP);
      chk("rst_pc", insn_pc, RESET_PC);
    end
    reset = 1'b0;
    model_clear(RESET_PC);
  endtask

  initial begin
    int n_req;
    logic [31:0] r;
    model_clear(RESET_PC);

    // Bring-up with memory returning the address as data.
    do_reset(3);
    cycle(1'b1, 1'b0, 32'h0);
    chkb("first_re", last_re, 1'b1);
    chk("first_addr", last_addr, RESET_PC);
    chkb("lat0_valid", last_valid, 1'b0);
    cycle(1'b1, 1'b0, 32'h0);
    chkb("lat1_valid", last_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chkb("steady_valid", last_valid, 1'b1);
      chk("steady_pc", last_pc, RESET_PC + 32'(4 * i));
    end

    // Decoder stalled straight out of reset.
    scramble = $urandom;
    do_reset(2);
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_req += int'(last_re);
    end
    chkb("stall_reqs", n_req <= QDEPTH, 1'b1);
    chkb("stall_valid", last_valid, 1'b1);
    chk("stall_head_pc", last_pc, RESET_PC);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0);

    // Redirect while popping with a response in flight.
    cycle(1'b1, 1'b1, 32'h100);
    chkb("redir_pop_coincident", last_valid, 1'b1);
    chk("redir_addr", last_addr, 32'h100);
    cycle(1'b1, 1'b0, 32'h0);
    chkb("post_redir_valid", last_valid, 1'b0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("redir_first_pc", last_pc, 32'h100);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    // Back-to-back redirects keep only the last stream.
    cycle(1'b1, 1'b1, 32'h200);
    cycle(1'b1, 1'b1, 32'h300);
    cycle(1'b1, 1'b1, 32'h400);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("b2b_pc", last_pc, 32'h400);

    // Address wrap at the top of the space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_pc0", last_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_pc1", last_pc, 32'h0000_0000);

`ifndef FETCH_MISALIGN_CHECK_EN
    // Low target bits are dropped.
    cycle(1'b1, 1'b1, 32'h0000_0206);
    chk("align_addr", last_addr, 32'h0000_0204);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
`endif

    // Reset in the middle of a running stream.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    do_reset(1);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chkb("mid_rst_valid", last_valid, 1'b1);
    chk("mid_rst_pc", last_pc, RESET_PC);

    // Random stalls and redirects.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      r[1:0] = 2'b00;
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, r);
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned target traps to a single flagged NOP and halts fetch.
    insn_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h102;
    #2;
    chkb("mis_no_issue", imem_re, 1'b0);
    @(posedge clk); #1;
    redirect_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chkb("mis_valid", insn_valid, 1'b1);
      chk("mis_insn", insn, NOP);
      chk("mis_pc", insn_pc, 32'h102);
      chkb("mis_flag", insn_misaligned, 1'b1);
      chkb("mis_halt_re", imem_re, 1'b0);
      @(posedge clk); #1;
    end
    insn_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chkb("mis_drained", insn_valid, 1'b0);
      chkb("mis_still_halted", imem_re, 1'b0);
      @(posedge clk); #1;
    end
    model_clear(32'h100);
    cycle(1'b1, 1'b1, 32'h100);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("mis_recover_pc", last_pc, 32'h100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
